// File: rtl/alu_exec_if.sv
// Execute-stage ALU bus: operation request side and result side.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and its payload stable until that edge, ready may not depend on valid.
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             br_taken;
  logic             ovf;

  modport master (
    output in_valid, alu_op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, br_taken, ovf
  );

  modport slave (
    input  in_valid, alu_op, a, b, flush, out_ready,
    output in_ready, out_valid, result, br_taken, ovf
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with registered result, branch flag and signed overflow.
// Shift/rotate optionally splits into a coarse (multiple of 4) and a fine step.
module alu_exec_stage #(
  parameter int WIDTH       = 16,
  parameter bit SHIFT_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  alu_exec_if.slave   bus,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    SHIFT2 = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic             accept;
  logic             is_shift;
  logic             split_shift;

  logic [WIDTH-1:0] partial;
  logic [3:0]       op_q;
  logic [1:0]       shamt_lo;

  logic [WIDTH:0]   sum17;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_br;
  logic             alu_ovf;

  // op[1:0] selects SLL / ROR / SRL / ROL for the 01xx group.
  function automatic logic [WIDTH-1:0] shift_fn(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] v,
    input logic [3:0]       amt
  );
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] dbl_r;
    logic [2*WIDTH-1:0] dbl_l;
    logic [WIDTH-1:0]   res;
    dbl   = {v, v};
    dbl_r = dbl >> amt;
    dbl_l = dbl << amt;
    case (op[1:0])
      2'b00:   res = v << amt;
      2'b01:   res = dbl_r[WIDTH-1:0];
      2'b10:   res = v >> amt;
      default: res = dbl_l[2*WIDTH-1:WIDTH];
    endcase
    return res;
  endfunction

  assign is_shift    = (bus.alu_op[3:2] == 2'b01);
  assign split_shift = SHIFT_SPLIT && is_shift;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign dbg_state    = state;

  assign sum17 = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff  = bus.b - bus.a;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ovf = 1'b0;
    case (bus.alu_op)
      4'b0000: begin
        alu_res = sum17[WIDTH-1:0];
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (sum17[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = diff;
        alu_ovf = (bus.b[WIDTH-1] != bus.a[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.b[WIDTH-1]);
      end
      4'b0010: alu_res = bus.a ^ bus.b;
      4'b0011: alu_res = bus.a & ~bus.b;
      4'b0100, 4'b0101, 4'b0110, 4'b0111:
        alu_res = shift_fn(bus.alu_op, bus.a, bus.b[3:0]);
      4'b1000: alu_br = (bus.a == '0);
      4'b1001: alu_br = (bus.a != '0);
      4'b1010: alu_br = bus.a[WIDTH-1];
      4'b1011: alu_br = !bus.a[WIDTH-1];
      4'b1100: alu_res = {{(WIDTH-1){1'b0}}, sum17[WIDTH]};
      4'b1101: alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      4'b1110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <  $signed(bus.b))};
      default: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <= $signed(bus.b))};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && split_shift) state_next = SHIFT2;
        SHIFT2:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flush wins over everything; a split shift clears out_valid because
  // acceptance already implies the previous output was consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.br_taken  <= 1'b0;
      bus.ovf       <= 1'b0;
      partial       <= '0;
      op_q          <= 4'b0000;
      shamt_lo      <= 2'b00;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (state == SHIFT2) begin
      bus.result    <= shift_fn(op_q, partial, {2'b00, shamt_lo});
      bus.br_taken  <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b1;
    end else if (accept) begin
      if (split_shift) begin
        partial       <= shift_fn(bus.alu_op, bus.a, {bus.b[3:2], 2'b00});
        op_q          <= bus.alu_op;
        shamt_lo      <= bus.b[1:0];
        bus.out_valid <= 1'b0;
      end else begin
        bus.result    <= alu_res;
        bus.br_taken  <= alu_br;
        bus.ovf       <= alu_ovf;
        bus.out_valid <= 1'b1;
      end
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
